// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA   = 32'hFFFF_FFFF;
    localparam int          ARB_DEFAULT_TIMEOUT = 255;

    // Watchdog counter is at least 8 bits, wider only if the timeout needs it.
    function automatic int arb_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: search starts just after the last winner.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus between NUM_MASTERS
// requesters, with a bus-timeout watchdog that force-completes hung transfers.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [31:0]               m_rdata,
    output logic                      s_valid,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic                      s_ready,
    input  logic [31:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]    grant,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic [31:0]               err_addr
);

    localparam int               IDX_W   = $clog2(NUM_MASTERS);
    localparam int               CNT_W   = arb_cnt_width(TIMEOUT_CYCLES);
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bus_err_q, bus_err_d;
    logic [31:0]            err_addr_q, err_addr_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_any;
    logic [IDX_W-1:0]       grant_idx;
    logic                   busy;
    logic                   timeout_hit;
    logic                   done;

    rr_pick #(
        .NUM_REQ (NUM_MASTERS)
    ) u_rr_pick (
        .req  (m_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) grant_idx = IDX_W'(i);
        end
    end

    // OR-mux on the registered one-hot grant; all zero while nobody owns the bus.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_addr  = s_addr  | m_addr[32*i +: 32];
                s_wdata = s_wdata | m_wdata[32*i +: 32];
                s_wstrb = s_wstrb | m_wstrb[4*i +: 4];
            end
        end
    end

    // A real s_ready on the timeout cycle takes precedence over the watchdog.
    assign busy        = (state_q == ARB_BUSY);
    assign timeout_hit = TO_EN && busy && !s_ready && (cnt_q == TO_LAST);
    assign done        = busy && (s_ready || timeout_hit);

    assign s_valid = busy;
    assign m_ready = (done && resetn) ? grant_q : '0;
    assign m_rdata = timeout_hit ? ARB_TIMEOUT_RDATA : s_rdata;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q & ~err_clr;
        err_addr_d = err_addr_q;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    last_d  = grant_idx;
                    cnt_d   = '0;
                    if (timeout_hit) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = s_addr;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(NUM_MASTERS - 1);
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign grant    = grant_q;
    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: two masters, a configurable slave model.
module tb_mem_bus_arbiter;

    localparam int          NM     = 2;
    localparam int          TO     = 16;
    localparam logic [31:0] RD_KEY = 32'h1234_5778;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NM-1:0]   m_valid;
    logic [NM*32-1:0] m_addr;
    logic [NM*32-1:0] m_wdata;
    logic [NM*4-1:0] m_wstrb;
    logic [NM-1:0]   m_ready;
    logic [31:0]     m_rdata;
    logic            s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_ready = 1'b0;
    logic [31:0]     s_rdata;
    logic [NM-1:0]   grant;
    logic            err_clr;
    logic            bus_err;
    logic [31:0]     err_addr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .err_clr  (err_clr),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t mq0[$], mq1[$];
    txn_t eq0[$], eq1[$];
    int   order_q[$];

    int         n_chk = 0;
    int         n_pass = 0;
    int         grant_multi = 0;
    logic [1:0] done_m = 2'b00;
    int         slave_mode = 0;
    int         slave_lat = 2;
    int         vcnt = 0;
    txn_t       mon_t;
    txn_t       drv_t;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave: mode 0 = SRAM-like (ready is last cycle's valid), 1 = never ready,
    // 2 = ready on BUSY cycle number slave_lat.
    assign s_rdata = s_addr ^ RD_KEY;

    always @(posedge clk) begin
        vcnt <= s_valid ? vcnt + 1 : 0;
        case (slave_mode)
            0:       s_ready <= s_valid;
            2:       s_ready <= s_valid && (vcnt + 2 == slave_lat);
            default: s_ready <= 1'b0;
        endcase
    end

    // Monitor: checks the slave-side mux each BUSY cycle and every completion.
    always @(negedge clk) begin
        done_m = 2'b00;
        if (resetn) begin
            if ($countones(grant) > 1) grant_multi++;
            if (s_valid) begin
                if (grant == 2'b01 && eq0.size() > 0)
                    check_eq("bus_mux_m0", {s_addr, s_wdata, s_wstrb},
                             {eq0[0].addr, eq0[0].wdata, eq0[0].wstrb});
                else if (grant == 2'b10 && eq1.size() > 0)
                    check_eq("bus_mux_m1", {s_addr, s_wdata, s_wstrb},
                             {eq1[0].addr, eq1[0].wdata, eq1[0].wstrb});
                else
                    check_eq("unexpected_busy", s_valid, 0);
            end
            if (m_ready != 2'b00) begin
                check_eq("m_ready_vs_grant", m_ready, grant);
                if (m_ready == 2'b01 && eq0.size() > 0) begin
                    mon_t = eq0.pop_front();
                    check_eq("rdata_m0", m_rdata, mon_t.rdata);
                    order_q.push_back(0);
                end else if (m_ready == 2'b10 && eq1.size() > 0) begin
                    mon_t = eq1.pop_front();
                    check_eq("rdata_m1", m_rdata, mon_t.rdata);
                    order_q.push_back(1);
                end else begin
                    check_eq("unexpected_m_ready", m_ready, 0);
                end
            end
            done_m = m_valid & m_ready;
        end
    end

    // Master driver: holds each request until its m_ready, then loads the next.
    initial begin
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (done_m[0]) m_valid[0] = 1'b0;
            if (done_m[1]) m_valid[1] = 1'b0;
            if (!m_valid[0] && mq0.size() > 0) begin
                drv_t = mq0.pop_front();
                m_addr[31:0]  = drv_t.addr;
                m_wdata[31:0] = drv_t.wdata;
                m_wstrb[3:0]  = drv_t.wstrb;
                m_valid[0]    = 1'b1;
            end
            if (!m_valid[1] && mq1.size() > 0) begin
                drv_t = mq1.pop_front();
                m_addr[63:32]  = drv_t.addr;
                m_wdata[63:32] = drv_t.wdata;
                m_wstrb[7:4]   = drv_t.wstrb;
                m_valid[1]     = 1'b1;
            end
        end
    end

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit to);
        txn_t t;
        t.addr  = a;
        t.wdata = wd;
        t.wstrb = ws;
        t.rdata = to ? 32'hFFFF_FFFF : (a ^ RD_KEY);
        if (m == 0) begin
            mq0.push_back(t);
            eq0.push_back(t);
        end else begin
            mq1.push_back(t);
            eq1.push_back(t);
        end
    endtask

    // Returns at the negedge of the first cycle the master's valid is high.
    task automatic wait_req(input int m);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid[m]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("wait_req_timeout", ok, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mq0.size() == 0 && mq1.size() == 0 && eq0.size() == 0 &&
                eq1.size() == 0 && m_valid == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("drain_done", ok, 1);
    endtask

    task automatic check_order(input string tag, input int a, input int b, input int c, input int n);
        int got;
        int exp_o[3];
        exp_o[0] = a;
        exp_o[1] = b;
        exp_o[2] = c;
        check_eq({tag, "_count"}, order_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (order_q.size() > 0) ? order_q.pop_front() : -1;
            check_eq({tag, "_order"}, got, exp_o[i]);
        end
        order_q.delete();
    endtask

    initial begin
        txn_t t;
        resetn  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_s_valid", s_valid, 0);
        check_eq("rst_m_ready", m_ready, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_err_addr", err_addr, 0);
        check_eq("rst_s_bus", {s_addr, s_wdata, s_wstrb}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Contention from reset: m0, m1, m0.
        order_q.delete();
        issue(0, 32'h0000_0200, 32'h0, 4'h0, 0);
        issue(1, 32'h0000_0300, 32'h0, 4'h0, 0);
        issue(0, 32'h0000_0204, 32'h0, 4'h0, 0);
        drain();
        check_order("contention", 0, 1, 0, 3);

        // Single master read with SRAM-like slave.
        issue(0, 32'h0000_0100, 32'h0, 4'h0, 0);
        wait_req(0);
        check_eq("single_T_s_valid", s_valid, 0);
        check_eq("single_T_grant", grant, 0);
        @(negedge clk);
        check_eq("single_T1_s_valid", s_valid, 1);
        check_eq("single_T1_grant", grant, 2'b01);
        check_eq("single_T1_m_ready", m_ready, 0);
        @(negedge clk);
        check_eq("single_T2_m_ready", m_ready, 2'b01);
        check_eq("single_T2_m_rdata", m_rdata, 32'h1234_5678);
        @(negedge clk);
        check_eq("single_T3_grant", grant, 0);
        check_eq("single_T3_s_valid", s_valid, 0);
        check_eq("single_T3_stale_ready", m_ready, 0);
        drain();

        // Write pass-through from master 1.
        issue(1, 32'h0020_0000, 32'hAABB_CCDD, 4'b0011, 0);
        wait_req(1);
        @(negedge clk);
        check_eq("write_s_bus", {s_addr, s_wdata, s_wstrb}, {32'h0020_0000, 32'hAABB_CCDD, 4'b0011});
        check_eq("write_grant", grant, 2'b10);
        drain();

        // Timeout with a slave that never answers.
        slave_mode = 1;
        issue(0, 32'h0400_0008, 32'h0, 4'h0, 1);
        wait_req(0);
        repeat (TO - 1) @(negedge clk);
        check_eq("to_T15_m_ready", m_ready, 0);
        @(negedge clk);
        check_eq("to_T16_m_ready", m_ready, 2'b01);
        check_eq("to_T16_rdata", m_rdata, 32'hFFFF_FFFF);
        check_eq("to_T16_bus_err", bus_err, 0);
        @(negedge clk);
        check_eq("to_T17_bus_err", bus_err, 1);
        check_eq("to_T17_err_addr", err_addr, 32'h0400_0008);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("clr_bus_err", bus_err, 0);
        check_eq("clr_err_addr_hold", err_addr, 32'h0400_0008);
        drain();

        // Second timeout with err_clr in the same cycle: set wins.
        issue(0, 32'h0400_0010, 32'h0, 4'h0, 1);
        wait_req(0);
        repeat (TO) @(negedge clk);
        check_eq("to2_m_ready", m_ready, 2'b01);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("to2_set_wins", bus_err, 1);
        check_eq("to2_err_addr", err_addr, 32'h0400_0010);
        drain();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("clr2_bus_err", bus_err, 0);

        // s_ready arriving on the exact timeout cycle.
        slave_mode = 2;
        slave_lat  = TO;
        issue(0, 32'h0400_0020, 32'h0, 4'h0, 0);
        wait_req(0);
        repeat (TO) @(negedge clk);
        check_eq("edge_m_ready", m_ready, 2'b01);
        check_eq("edge_rdata", m_rdata, 32'h0400_0020 ^ RD_KEY);
        @(negedge clk);
        check_eq("edge_bus_err", bus_err, 0);
        check_eq("edge_err_addr", err_addr, 32'h0400_0010);
        drain();

        // Reset during a stalled transaction.
        slave_mode = 1;
        issue(0, 32'h0000_0500, 32'h0, 4'h0, 1);
        wait_req(0);
        repeat (5) @(negedge clk);
        check_eq("rstb_busy", s_valid, 1);
        resetn = 1'b0;
        issue(1, 32'h0000_0600, 32'h0, 4'h0, 0);
        @(negedge clk);
        check_eq("rstb_grant", grant, 0);
        check_eq("rstb_s_valid", s_valid, 0);
        check_eq("rstb_m_ready", m_ready, 0);
        check_eq("rstb_err_addr", err_addr, 0);
        check_eq("rstb_s_bus", {s_addr, s_wdata, s_wstrb}, 0);
        t = eq0.pop_front();
        t.rdata = t.addr ^ RD_KEY;
        eq0.push_front(t);
        order_q.delete();
        slave_mode = 0;
        resetn = 1'b1;
        drain();
        check_order("post_reset", 0, 1, 0, 2);

        check_eq("grant_onehot", grant_multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got stuck expected finish");
        $fatal(1, "watchdog");
    end

endmodule
